// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
//   Runs a programmed list of SPI words through spi_controller. Each list
//   entry is one SPI transaction, with a programmable idle gap between
//   entries. The whole list can be repeated several times. Every received
//   word is forwarded to result storage together with its command index.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   kick_i / busy_o       run start pulse / run in progress
//   abort_i               stop once the in-flight SPI transaction completes
//   cmd_we_i/_waddr_i/_wdata_i   command RAM write port (used only while idle)
//   num_cmds_i, loop_count_i, gap_i   run configuration, sampled at kick
//   spi_kick_o, spi_busy_i, spi_din_o, spi_dout_i, spi_dout_valid_i
//                         spi_controller handshake
//   res_data_o, res_idx_o, res_we_o   result write toward result storage
//   done_o                1-cycle end-of-run pulse
//   status_o              [0] aborted, [1] ack timeout; sticky until next run

module spi_cmd_sequencer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  kick_i,
    output logic                  busy_o,
    input  logic                  abort_i,
    input  logic                  cmd_we_i,
    input  logic [DEPTH_LOG2-1:0] cmd_waddr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [DEPTH_LOG2:0]   num_cmds_i,
    input  logic [7:0]            loop_count_i,
    input  logic [15:0]           gap_i,
    output logic                  spi_kick_o,
    input  logic                  spi_busy_i,
    output logic [DATA_WIDTH-1:0] spi_din_o,
    input  logic [DATA_WIDTH-1:0] spi_dout_i,
    input  logic                  spi_dout_valid_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic [DEPTH_LOG2-1:0] res_idx_o,
    output logic                  res_we_o,
    output logic                  done_o,
    output logic [1:0]            status_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_WAIT_END = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    localparam logic [15:0]           TMR_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [DEPTH_LOG2-1:0] IDX_INC  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_INC  = 1;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    logic [2:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [7:0]            loop_q, loop_d;
    logic [15:0]           gap_cnt_q, gap_cnt_d;
    logic [15:0]           timer_q, timer_d;
    logic [1:0]            status_q, status_d;
    logic                  busy_q, busy_d;
    logic                  abort_q, abort_d;

    logic [DEPTH_LOG2:0]   num_q;
    logic [7:0]            loops_q;
    logic [15:0]           gap_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [DEPTH_LOG2-1:0] res_idx_q;
    logic                  res_we_q;

    logic       abort_any;
    logic       idx_more;
    logic       loop_more;
    logic [7:0] loop_max;

    assign abort_any = abort_i | abort_q;
    assign loop_max  = (loops_q == 8'd0) ? 8'd1 : loops_q;
    assign idx_more  = ({1'b0, idx_q} + CNT_INC) < num_q;
    assign loop_more = (loop_q + 8'd1) < loop_max;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loop_d    = loop_q;
        gap_cnt_d = gap_cnt_q;
        timer_d   = timer_q;
        status_d  = status_q;
        busy_d    = busy_q;
        abort_d   = abort_q;

        if (state_q != S_IDLE && abort_i) abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                // An empty list still produces a DONE pulse, without ever
                // raising BUSY or touching the SPI side.
                if (kick_i) begin
                    if (num_cmds_i != '0) begin
                        state_d  = S_FETCH;
                        busy_d   = 1'b1;
                        status_d = 2'b00;
                        idx_d    = '0;
                        loop_d   = '0;
                        abort_d  = 1'b0;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FETCH: begin
                if (abort_any) begin
                    state_d     = S_FINISH;
                    status_d[0] = 1'b1;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_any) begin
                    state_d     = S_FINISH;
                    status_d[0] = 1'b1;
                end else begin
                    state_d = S_WAIT_ACK;
                    timer_d = '0;
                end
            end
            S_WAIT_ACK: begin
                if (abort_any) begin
                    state_d     = S_FINISH;
                    status_d[0] = 1'b1;
                end else if (spi_busy_i) begin
                    state_d = S_WAIT_END;
                end else if (timer_q == TMR_LAST) begin
                    state_d     = S_FINISH;
                    status_d[1] = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_WAIT_END: begin
                // Abort is honoured only after the controller goes idle so
                // the in-flight result still reaches result storage.
                if (!spi_busy_i) begin
                    if (abort_any) begin
                        state_d     = S_FINISH;
                        status_d[0] = 1'b1;
                    end else if (idx_more || loop_more) begin
                        if (idx_more) begin
                            idx_d = idx_q + IDX_INC;
                        end else begin
                            idx_d  = '0;
                            loop_d = loop_q + 8'd1;
                        end
                        gap_cnt_d = '0;
                        state_d   = (gap_q == 16'd0) ? S_FETCH : S_GAP;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_GAP: begin
                if (abort_any) begin
                    state_d     = S_FINISH;
                    status_d[0] = 1'b1;
                end else if (gap_cnt_q + 16'd1 == gap_q) begin
                    state_d = S_FETCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                abort_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command RAM: writes locked out for the duration of a run.
    always_ff @(posedge clk_i) begin
        if (cmd_we_i && !busy_q) mem[cmd_waddr_i] <= cmd_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            loop_q     <= '0;
            gap_cnt_q  <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            num_q      <= '0;
            loops_q    <= '0;
            gap_q      <= '0;
            din_q      <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            res_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            loop_q    <= loop_d;
            gap_cnt_q <= gap_cnt_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
            busy_q    <= busy_d;
            abort_q   <= abort_d;

            if (state_q == S_IDLE && kick_i) begin
                num_q   <= num_cmds_i;
                loops_q <= loop_count_i;
                gap_q   <= gap_i;
            end

            // Synchronous RAM read lands in the SPI_DIN register, ready
            // in the ISSUE cycle alongside the kick.
            if (state_q == S_FETCH) din_q <= mem[idx_q];

            res_we_q <= 1'b0;
            if (state_q != S_IDLE && spi_dout_valid_i) begin
                res_data_q <= spi_dout_i;
                res_idx_q  <= idx_q;
                res_we_q   <= 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign spi_kick_o = (state_q == S_ISSUE) && !abort_any;
    assign spi_din_o  = din_q;
    assign res_data_o = res_data_q;
    assign res_idx_o  = res_idx_q;
    assign res_we_o   = res_we_q;
    assign done_o     = (state_q == S_FINISH);
    assign status_o   = status_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: a randomized SPI controller responder, a
// passive monitor that logs kicks/results/done pulses, and a per-run
// reference model that derives the expected index order, data and timing
// from the run configuration.

module tb_spi_cmd_sequencer;

    localparam int DL = 4;
    localparam int DW = 32;
    localparam int AT = 15;

    logic          clk = 1'b0;
    logic          reset, kick, abort_s, cmd_we;
    logic [DL-1:0] cmd_waddr;
    logic [DW-1:0] cmd_wdata;
    logic [DL:0]   num_cmds;
    logic [7:0]    loop_count;
    logic [15:0]   gap_cfg;
    logic          spi_busy, spi_dout_valid;
    logic [DW-1:0] spi_dout;
    logic          busy_o, spi_kick_o, res_we_o, done_o;
    logic [DW-1:0] spi_din_o, res_data_o;
    logic [DL-1:0] res_idx_o;
    logic [1:0]    status_o;

    always #5 clk = ~clk;

    spi_cmd_sequencer #(.DEPTH_LOG2(DL), .DATA_WIDTH(DW), .ACK_TIMEOUT(AT)) dut (
        .clk_i(clk), .reset_i(reset), .kick_i(kick), .busy_o(busy_o),
        .abort_i(abort_s), .cmd_we_i(cmd_we), .cmd_waddr_i(cmd_waddr),
        .cmd_wdata_i(cmd_wdata), .num_cmds_i(num_cmds), .loop_count_i(loop_count),
        .gap_i(gap_cfg), .spi_kick_o(spi_kick_o), .spi_busy_i(spi_busy),
        .spi_din_o(spi_din_o), .spi_dout_i(spi_dout), .spi_dout_valid_i(spi_dout_valid),
        .res_data_o(res_data_o), .res_idx_o(res_idx_o), .res_we_o(res_we_o),
        .done_o(done_o), .status_o(status_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            kq_cyc[$];
    logic [DW-1:0] kq_din[$];
    logic          kq_busy[$];
    logic [DL-1:0] rq_idx[$];
    logic [DW-1:0] rq_data[$];
    int            dq_cyc[$];
    logic [1:0]    dq_st[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (spi_kick_o) begin
            kq_cyc.push_back(cyc);
            kq_din.push_back(spi_din_o);
            kq_busy.push_back(busy_o);
        end
        if (res_we_o) begin
            rq_idx.push_back(res_idx_o);
            rq_data.push_back(res_data_o);
        end
        if (done_o) begin
            dq_cyc.push_back(cyc);
            dq_st.push_back(status_o);
        end
    end

    // ---------------- SPI controller responder ----------------
    // slave_mode: 0 normal, 1 abort during 2nd transaction, 2 never answer
    int            slave_mode = 0;
    int            fall_base  = 0;
    int            fall_q[$];
    logic [DW-1:0] exp_dout_q[$];
    logic [DW-1:0] sd;
    int            stn, slat, slen;

    initial begin
        abort_s = 1'b0; spi_busy = 1'b0; spi_dout = '0; spi_dout_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (spi_kick_o && slave_mode != 2) begin
                sd   = spi_din_o;
                stn  = fall_q.size() - fall_base;
                slat = $urandom_range(1, 3);
                slen = (slave_mode == 1 && stn == 1) ? 4 : $urandom_range(1, 5);
                repeat (slat) begin
                    @(posedge clk); #1;
                    chk("din_hold", spi_din_o, sd);
                end
                spi_busy = 1'b1;
                for (int c = 0; c < slen; c++) begin
                    if (c > 0) begin @(posedge clk); #1; end
                    abort_s = (slave_mode == 1 && stn == 1 && c == 1);
                    if (c == slen - 1) begin
                        spi_dout       = sd ^ $urandom();
                        spi_dout_valid = 1'b1;
                        exp_dout_q.push_back(spi_dout);
                    end
                    chk("din_hold", spi_din_o, sd);
                end
                @(posedge clk); #1;
                spi_busy = 1'b0; spi_dout_valid = 1'b0; abort_s = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus / reference model ----------------
    logic [DW-1:0] ram_m [2**DL];

    task automatic step;
        @(posedge clk); #2;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        cmd_we = 1'b1; cmd_waddr = DL'(a); cmd_wdata = d;
        step;
        cmd_we = 1'b0;
        ram_m[a] = d;
    endtask

    task automatic run(input int num, input int loops, input int gap, input int mode, input bit poke_we);
        int kb, rb, fb, db, eb, kc, n, lm, t_exp;
        int idxs[$];
        kb = kq_cyc.size(); rb = rq_idx.size(); fb = fall_q.size();
        db = dq_cyc.size(); eb = exp_dout_q.size();
        fall_base  = fb;
        slave_mode = mode;
        num_cmds = (DL+1)'(num); loop_count = 8'(loops); gap_cfg = 16'(gap);
        kick = 1'b1; kc = cyc;
        step;
        kick = 1'b0;
        // configuration is sampled at kick; later changes must not matter
        num_cmds = (DL+1)'($urandom); loop_count = 8'($urandom); gap_cfg = 16'($urandom_range(0, 9));
        chk("status_clr", status_o, 0);
        chk("busy_rise", busy_o, 1);
        if (poke_we) begin
            cmd_we = 1'b1; cmd_waddr = '0; cmd_wdata = ~ram_m[0];
            step;
            cmd_we = 1'b0;
        end
        for (int w = 0; w < 4000 && dq_cyc.size() == db; w++) step;
        chk("done_cnt", dq_cyc.size() - db, 1);

        lm = (loops == 0) ? 1 : loops;
        for (int l = 0; l < lm; l++)
            for (int i = 0; i < num; i++) idxs.push_back(i);
        n = idxs.size();
        if (mode == 1) n = 2;
        if (mode == 2) n = 1;

        chk("kick_cnt", kq_cyc.size() - kb, n);
        for (int j = 0; j < n && kb + j < kq_cyc.size(); j++) begin
            chk("kick_din", kq_din[kb+j], ram_m[idxs[j]]);
            chk("kick_busy", kq_busy[kb+j], 1);
            if (j == 0) chk("kick_lat", kq_cyc[kb], kc + 2);
            else if (fb + j - 1 < fall_q.size()) chk("kick_gap", kq_cyc[kb+j], fall_q[fb+j-1] + 2 + gap);
        end
        chk("res_cnt", rq_idx.size() - rb, (mode == 2) ? 0 : n);
        for (int j = 0; j < n && mode != 2 && rb + j < rq_idx.size() && eb + j < exp_dout_q.size(); j++) begin
            chk("res_idx", rq_idx[rb+j], idxs[j]);
            chk("res_data", rq_data[rb+j], exp_dout_q[eb+j]);
        end
        if (dq_cyc.size() > db) begin
            if (mode == 2) t_exp = (kq_cyc.size() > kb) ? kq_cyc[kb] + 1 + AT : -1;
            else           t_exp = (fall_q.size() >= fb + n) ? fall_q[fb+n-1] + 1 : -1;
            chk("done_time", dq_cyc[db], t_exp);
            chk("done_status", dq_st[db], (mode == 1) ? 2'b01 : (mode == 2) ? 2'b10 : 2'b00);
        end
        step;
        chk("busy_fall", busy_o, 0);
        slave_mode = 0;
        step;
    endtask

    initial begin
        int kb, db, fb;
        reset = 1'b1; kick = 1'b0; cmd_we = 1'b0; cmd_waddr = '0; cmd_wdata = '0;
        num_cmds = '0; loop_count = '0; gap_cfg = '0;
        repeat (3) step;
        chk("rst_busy", busy_o, 0);
        chk("rst_kick", spi_kick_o, 0);
        chk("rst_din", spi_din_o, 0);
        chk("rst_res_we", res_we_o, 0);
        chk("rst_res_data", res_data_o, 0);
        chk("rst_res_idx", res_idx_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_status", status_o, 0);
        reset = 1'b0;
        step;

        for (int i = 0; i < 2**DL; i++) wr(i, $urandom());
        wr(0, 32'hAAAA_0001); wr(1, 32'hBBBB_0002); wr(2, 32'hCCCC_0003);
        run(3, 1, 4, 0, 1'b0);                        // basic list
        run(2, 3, $urandom_range(0, 3), 0, 1'b1);     // looping + locked-out write

        // empty list: DONE next cycle, no BUSY, no SPI activity
        kb = kq_cyc.size(); db = dq_cyc.size();
        num_cmds = '0; loop_count = 8'd2; gap_cfg = 16'd1; kick = 1'b1;
        step;
        kick = 1'b0;
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        repeat (5) step;
        chk("zero_kicks", kq_cyc.size() - kb, 0);
        chk("zero_done_cnt", dq_cyc.size() - db, 1);

        run(4, 1, 2, 1, 1'b0);                        // abort in 2nd WAIT_END
        run(3, 1, 1, 2, 1'b0);                        // ack timeout
        run(2, 1, 0, 0, 1'b0);                        // status cleared again

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) wr($urandom_range(0, 2**DL - 1), $urandom());
            run($urandom_range(1, 5), $urandom_range(0, 2), $urandom_range(0, 5), 0, 1'b0);
        end
        run(16, 1, 0, 0, 1'b0);                       // full RAM, no gap
        run(1, 0, 3, 0, 1'b0);                        // LOOP_COUNT 0 acts as 1

        // reset in the middle of a gap
        kb = kq_cyc.size(); db = dq_cyc.size(); fb = fall_q.size();
        fall_base = fb;
        num_cmds = (DL+1)'(3); loop_count = 8'd1; gap_cfg = 16'd20; kick = 1'b1;
        step;
        kick = 1'b0;
        for (int w = 0; w < 500 && fall_q.size() == fb; w++) step;
        chk("rst_gap_txn", fall_q.size() - fb, 1);
        repeat (2) step;
        reset = 1'b1;
        step;
        chk("mid_busy", busy_o, 0);
        chk("mid_kick", spi_kick_o, 0);
        chk("mid_din", spi_din_o, 0);
        chk("mid_res_we", res_we_o, 0);
        chk("mid_res_data", res_data_o, 0);
        chk("mid_done", done_o, 0);
        chk("mid_status", status_o, 0);
        reset = 1'b0;
        repeat (40) step;
        chk("mid_no_done", dq_cyc.size() - db, 0);
        chk("mid_kicks", kq_cyc.size() - kb, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
